dht11_poll_ctrl: RTL and testbench
==================================

# dht11_poll_ctrl

Scheduling controller for the DHT11 single-wire frame reader. It decides when a read runs, either on a periodic timer or on host request, and enforces the sensor's minimum spacing between reads. It supervises each read with a timeout, verifies the checksum, retries failed reads, and publishes the last good humidity/temperature sample. It sits between the host logic and the reader datapath, which drives the `Data` line and returns a 40-bit frame.

## Interface
Parameters:
- `PERIOD_CYC`, default 2_000_000: periodic read interval in `clk` cycles (2 s at 1 MHz).
- `MIN_GAP_CYC`, default 1_000_000: minimum idle cycles between the end of one read and the next `rd_start`.
- `TIMEOUT_CYC`, default 30_000: maximum cycles from `rd_start` to `rd_done`.
- `MAX_RETRY`, default 3: extra attempts after a failed read before declaring failure.

Ports:
- `clk` in 1: single clock, 1 MHz nominal.
- `nRST` in 1: asynchronous, active-low reset.
- `en` in 1: enables periodic polling.
- `req` in 1: one-cycle host request for an immediate read.
- `ack` out 1: one-cycle pulse when a read sequence finishes (success or final failure).
- `rd_start` out 1: one-cycle pulse that launches the reader.
- `rd_abort` out 1: one-cycle pulse that forces the reader back to idle.
- `rd_done` in 1: one-cycle pulse, reader frame complete.
- `rd_frame` in 40: `[39:32]` humidity integer, `[31:24]` humidity decimal, `[23:16]` temperature integer, `[15:8]` temperature decimal, `[7:0]` checksum.
- `hum_int`, `hum_dec`, `tmp_int`, `tmp_dec` out 8 each: last good sample.
- `valid` out 1: at least one good sample held.
- `fail` out 1: last sequence exhausted its retries. Cleared by the next success.
- `err_cnt` out 8: failed sequences, saturating at 255.
- `busy` out 1: high in START, WAIT and CHECK.

## Operation
- Reset values: all outputs 0. State is GAP. All counters 0. `due` and `req_pend` are 0.
- Period timer:
  - Counts only while `en=1`.
  - At `PERIOD_CYC-1` it wraps and sets `due`.
  - When `en=0` the timer is held at 0 and `due` is cleared.
- `req` sets `req_pend`. A `req` that arrives while `req_pend` is already set merges with it.
- GAP state:
  - `gap_cnt` counts up and saturates at `MIN_GAP_CYC`.
  - Transition to START when `gap_cnt==MIN_GAP_CYC` and any of `due`, `req_pend` or `retry_pend` is set.
  - After reset the first read therefore waits `MIN_GAP_CYC`, which covers sensor power-up.
- START state:
  - Assert `rd_start`.
  - Clear `due`, `retry_pend`, `gap_cnt` and `to_cnt`.
  - Go to WAIT.
- WAIT state:
  - On `rd_done`, capture `rd_frame` and go to CHECK.
  - Otherwise, when `to_cnt==TIMEOUT_CYC-1`, pulse `rd_abort` and take the failure path.
  - If `rd_done` and timeout coincide, `rd_done` wins.
- CHECK state:
  - Pass condition: `(b4+b3+b2+b1) mod 256 == b0`.
  - On pass:
    - Latch the four data bytes.
    - Set `valid=1` and `fail=0`.
    - Clear `retry`.
    - Pulse `ack` if `req_pend`, then clear `req_pend`.
    - Go to GAP.
- Failure path (bad checksum or timeout):
  - If `retry<MAX_RETRY`: increment `retry`, set `retry_pend`, go to GAP.
  - Otherwise:
    - Set `fail=1`.
    - Increment `err_cnt` (saturating).
    - Clear `retry`.
    - Pulse `ack` if `req_pend`, then clear `req_pend`.
    - Go to GAP.
    - Previous data and `valid` are retained.
- `ack` is driven only for host-requested sequences. A `req` during a periodic read is served by that same read.
- `rd_done` outside WAIT is ignored.
- Dropping `en` mid-read does not abort the read.
- Asserting `nRST` mid-read returns everything to reset values immediately. The reader is reset by the same `nRST`.

## Timing
- `rd_start` is asserted one cycle after the GAP exit condition is true.
- `rd_done` sampled at cycle t: CHECK runs at t+1, and data, `valid`, `fail` and `ack` are visible at t+2.
- Timeout: with `rd_start` at cycle s, `rd_abort` fires at s+`TIMEOUT_CYC`.
- Retry spacing: the next `rd_start` comes no sooner than `MIN_GAP_CYC`+1 cycles after the failure.
- Checksum arithmetic is 8-bit with wrap-around. Carries are discarded.

## Structure
- Package `dht11_pkg` holds:
  - the state enum (GAP, START, WAIT, CHECK);
  - localparams for the frame byte offsets;
  - a `dht11_csum_ok` function.
- One sub-module is natural: `dht11_interval_timer`, which implements the period counter with `en` hold and the wrap pulse.
- Everything else is flat in `dht11_poll_ctrl`.

## Test plan
Test parameters: `PERIOD_CYC`=100, `MIN_GAP_CYC`=20, `TIMEOUT_CYC`=50, `MAX_RETRY`=2.
- Periodic good read: `en=1`, reader returns `32_00_19_00_4B` → `hum_int`=0x32, `tmp_int`=0x19 and `valid=1` two cycles after `rd_done`; `ack` stays 0.
- Host request: `req` pulse with `en=0` → `rd_start` once `gap_cnt` reaches 20; `rd_done` with a good frame → `ack` is a single pulse, coincident with the data update.
- Bad checksum: frame `32_00_19_00_4C` three times → 3 `rd_start` pulses spaced ≥21 cycles apart; then `fail=1`, `err_cnt=1`, and the old data is retained.
- Timeout: reader never responds → `rd_abort` 50 cycles after each `rd_start`; after 3 attempts `fail=1`. A later good read clears `fail`.
- Merge and coincidence: `req` in the same cycle as `due` → exactly one `rd_start` and one `ack`. `rd_done` in the same cycle as the timeout edge → treated as done, no `rd_abort`.
- Reset mid-WAIT: drop `nRST` → all outputs 0 and state GAP; the next `rd_start` comes no earlier than 21 cycles after release.

Source files
------------

// File: rtl/dht11_pkg.sv
// Shared types and helpers for the DHT11 poll controller: FSM states,
// frame byte positions and the frame checksum test.
package dht11_pkg;

  typedef enum logic [1:0] {
    ST_GAP,
    ST_START,
    ST_WAIT,
    ST_CHECK
  } state_t;

  localparam int unsigned FRAME_W     = 40;
  localparam int unsigned HUM_INT_LSB = 32;
  localparam int unsigned HUM_DEC_LSB = 24;
  localparam int unsigned TMP_INT_LSB = 16;
  localparam int unsigned TMP_DEC_LSB = 8;
  localparam int unsigned CSUM_LSB    = 0;

  // 8-bit wrap-around sum of the four data bytes must equal the checksum byte
  function automatic logic dht11_csum_ok(input logic [FRAME_W-1:0] frame);
    logic [7:0] sum;
    sum = frame[HUM_INT_LSB +: 8] + frame[HUM_DEC_LSB +: 8]
        + frame[TMP_INT_LSB +: 8] + frame[TMP_DEC_LSB +: 8];
    return sum == frame[CSUM_LSB +: 8];
  endfunction

endpackage

// File: rtl/dht11_interval_timer.sv
// Free-running period counter; held at zero while disabled, wrap pulse on the
// last count of each period.
module dht11_interval_timer #(
  parameter int unsigned PERIOD_CYC = 2_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_wrap
);

  localparam int unsigned CW = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_at_end;

  assign w_at_end = (r_cnt == CW'(PERIOD_CYC - 1));
  assign o_wrap   = i_en && w_at_end;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                r_cnt <= '0;
    else if (!i_en || w_at_end)  r_cnt <= '0;
    else                         r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/dht11_poll_ctrl.sv
// DHT11 read scheduler: periodic/host-triggered reads with minimum spacing,
// timeout supervision, checksum verification, retries and sample publication.
module dht11_poll_ctrl
  import dht11_pkg::*;
#(
  parameter int unsigned PERIOD_CYC  = 2_000_000,
  parameter int unsigned MIN_GAP_CYC = 1_000_000,
  parameter int unsigned TIMEOUT_CYC = 30_000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic               clk,
  input  logic               nRST,
  input  logic               en,
  input  logic               req,
  output logic               ack,
  output logic               rd_start,
  output logic               rd_abort,
  input  logic               rd_done,
  input  logic [FRAME_W-1:0] rd_frame,
  output logic [7:0]         hum_int,
  output logic [7:0]         hum_dec,
  output logic [7:0]         tmp_int,
  output logic [7:0]         tmp_dec,
  output logic               valid,
  output logic               fail,
  output logic [7:0]         err_cnt,
  output logic               busy
);

  localparam int unsigned GW = (MIN_GAP_CYC > 0) ? $clog2(MIN_GAP_CYC + 1) : 1;
  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_t             r_state, w_next;
  logic [GW-1:0]      r_gap_cnt;
  logic [TW-1:0]      r_to_cnt;
  logic [RW-1:0]      r_retry;
  logic               r_due, r_req_pend, r_retry_pend, r_ack;
  logic               r_valid, r_fail;
  logic [7:0]         r_err_cnt;
  logic [31:0]        r_sample;
  logic [FRAME_W-1:0] r_frame;

  logic w_wrap, w_gap_full, w_timeout, w_pass, w_fail, w_retry_ok, w_finish;

  dht11_interval_timer #(.PERIOD_CYC(PERIOD_CYC)) u_timer (
    .i_clk   (clk),
    .i_rst_n (nRST),
    .i_en    (en),
    .o_wrap  (w_wrap)
  );

  assign w_gap_full = (r_gap_cnt == GW'(MIN_GAP_CYC));
  assign w_timeout  = (r_to_cnt == TW'(TIMEOUT_CYC - 1));
  assign w_retry_ok = (r_retry < RW'(MAX_RETRY));
  assign w_finish   = w_pass || (w_fail && !w_retry_ok);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) r_state <= ST_GAP;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_GAP:   if (w_gap_full && (r_due || r_req_pend || r_retry_pend)) w_next = ST_START;
      ST_START: w_next = ST_WAIT;
      ST_WAIT:  if (rd_done) w_next = ST_CHECK;
                else if (w_timeout) w_next = ST_GAP;
      ST_CHECK: w_next = ST_GAP;
      default:  w_next = ST_GAP;
    endcase
  end

  // rd_done on the timeout edge takes priority, so the abort is suppressed
  always_comb begin
    rd_start = 1'b0;
    rd_abort = 1'b0;
    busy     = 1'b0;
    w_pass   = 1'b0;
    w_fail   = 1'b0;
    case (r_state)
      ST_START: begin
        rd_start = 1'b1;
        busy     = 1'b1;
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (!rd_done && w_timeout) begin
          rd_abort = 1'b1;
          w_fail   = 1'b1;
        end
      end
      ST_CHECK: begin
        busy   = 1'b1;
        w_pass = dht11_csum_ok(r_frame);
        w_fail = !dht11_csum_ok(r_frame);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_gap_cnt <= '0;
      r_to_cnt  <= '0;
      r_frame   <= '0;
    end else begin
      if (r_state == ST_START)                     r_gap_cnt <= '0;
      else if (r_state == ST_GAP && !w_gap_full)   r_gap_cnt <= r_gap_cnt + 1'b1;
      if (r_state == ST_START)                     r_to_cnt <= '0;
      else if (r_state == ST_WAIT && !w_timeout)   r_to_cnt <= r_to_cnt + 1'b1;
      if (r_state == ST_WAIT && rd_done)           r_frame <= rd_frame;
    end
  end

  // A req arriving on the finishing cycle is folded into that sequence's ack
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_due        <= 1'b0;
      r_req_pend   <= 1'b0;
      r_retry_pend <= 1'b0;
      r_retry      <= '0;
      r_ack        <= 1'b0;
    end else begin
      if (!en)                       r_due <= 1'b0;
      else if (w_wrap)               r_due <= 1'b1;
      else if (r_state == ST_START)  r_due <= 1'b0;

      if (w_finish)                  r_req_pend <= 1'b0;
      else if (req)                  r_req_pend <= 1'b1;

      if (r_state == ST_START)       r_retry_pend <= 1'b0;
      else if (w_fail && w_retry_ok) r_retry_pend <= 1'b1;

      if (w_pass)                    r_retry <= '0;
      else if (w_fail)               r_retry <= w_retry_ok ? r_retry + 1'b1 : '0;

      r_ack <= w_finish && (r_req_pend || req);
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_sample  <= '0;
      r_valid   <= 1'b0;
      r_fail    <= 1'b0;
      r_err_cnt <= '0;
    end else if (w_pass) begin
      r_sample <= r_frame[TMP_DEC_LSB +: 32];
      r_valid  <= 1'b1;
      r_fail   <= 1'b0;
    end else if (w_fail && !w_retry_ok) begin
      r_fail <= 1'b1;
      if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign hum_int = r_sample[31:24];
  assign hum_dec = r_sample[23:16];
  assign tmp_int = r_sample[15:8];
  assign tmp_dec = r_sample[7:0];
  assign valid   = r_valid;
  assign fail    = r_fail;
  assign err_cnt = r_err_cnt;
  assign ack     = r_ack;

endmodule

// File: tb/tb_dht11_poll_ctrl.sv
// Bench for dht11_poll_ctrl: the bench plays host and reader, predicts event
// cycles from the scheduling rules and scores DUT outputs from a monitor.
module tb_dht11_poll_ctrl;

  localparam int unsigned P  = 100;
  localparam int unsigned G  = 20;
  localparam int unsigned TO = 50;
  localparam int unsigned MR = 2;

  logic        clk = 1'b0, nRST = 1'b0, en = 1'b0, req = 1'b0, rd_done = 1'b0;
  logic [39:0] rd_frame = '0;
  logic        ack, rd_start, rd_abort, valid, fail, busy;
  logic [7:0]  hum_int, hum_dec, tmp_int, tmp_dec, err_cnt;

  dht11_poll_ctrl #(
    .PERIOD_CYC  (P),
    .MIN_GAP_CYC (G),
    .TIMEOUT_CYC (TO),
    .MAX_RETRY   (MR)
  ) dut (
    .clk(clk), .nRST(nRST), .en(en), .req(req), .ack(ack),
    .rd_start(rd_start), .rd_abort(rd_abort), .rd_done(rd_done), .rd_frame(rd_frame),
    .hum_int(hum_int), .hum_dec(hum_dec), .tmp_int(tmp_int), .tmp_dec(tmp_dec),
    .valid(valid), .fail(fail), .err_cnt(err_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic [31:0] data;
    logic        valid;
    logic        fail;
    logic        ack;
    logic [7:0]  err;
  } out_t;

  int unsigned q_start[$];
  int unsigned q_abort[$];
  out_t        q_out[$];
  int          n_chk = 0;
  int          n_fail = 0;

  // reference state: published sample, flags, retry count, cycle where the gap restarts
  logic [31:0] m_data = '0;
  logic        m_valid = 1'b0, m_fail = 1'b0;
  logic [7:0]  m_err = '0;
  int unsigned m_retry = 0;
  int unsigned gb = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick_to(input int unsigned k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [39:0] mk_frame(input bit good);
    logic [7:0] b[4];
    int         sum;
    logic [7:0] cs;
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      b[i] = 8'($urandom);
      sum += int'(b[i]);
    end
    cs = 8'(sum % 256);
    if (!good) cs = cs ^ 8'($urandom_range(1, 255));
    return {b[0], b[1], b[2], b[3], cs};
  endfunction

  function automatic bit model_csum(input logic [39:0] f);
    int sum;
    sum = int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8]);
    return (sum % 256) == int'(f[7:0]);
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_data"}, {hum_int, hum_dec, tmp_int, tmp_dec}, '0);
    chk({tag, "_err"}, err_cnt, '0);
    chk({tag, "_flags"}, {valid, fail, ack, rd_start, rd_abort, busy}, '0);
  endtask

  // kind: 0 host req, 1 periodic, 2 req together with period wrap,
  //       3 periodic with req during the read, 4 periodic with en dropped mid-read,
  //       5 host req then reset mid-WAIT
  // response code per attempt: 0 good, 1 bad checksum, 2 no response, 3 good on timeout edge
  task automatic do_seq(input int kind, input int r0, input int r1, input int r2,
                        input bit fixed, input logic [39:0] ffr);
    int          rsp[3];
    int unsigned s, d, E, trig, rq, e0, last;
    bit          served, ok, fin, has_done;
    int          att;
    logic [39:0] fr;
    logic [63:0] junk;
    out_t        o;
    rsp[0] = r0; rsp[1] = r1; rsp[2] = r2;
    served = 1'b0;
    att = 0;
    if (kind == 0 || kind == 5) begin
      rq = cyc + $urandom_range(0, 30);
      tick_to(rq);
      req = 1'b1;
      tick_to(rq + 1);
      req = 1'b0;
      trig = rq + 1;
      served = 1'b1;
    end else begin
      e0 = cyc;
      en = 1'b1;
      trig = e0 + P;
      if (kind == 2) begin
        tick_to(e0 + P - 1);
        req = 1'b1;
        tick_to(e0 + P);
        req = 1'b0;
        served = 1'b1;
      end
    end
    s = (((gb + G) > trig) ? (gb + G) : trig) + 1;
    fin = 1'b0;
    while (!fin) begin
      q_start.push_back(s);
      if (kind == 5) begin
        tick_to(s + 5);
        nRST = 1'b0;
        #1;
        check_reset("rst_midwait");
        tick_to(s + 8);
        nRST = 1'b1;
        gb = s + 8;
        m_data = '0; m_valid = 1'b0; m_fail = 1'b0; m_err = '0; m_retry = 0;
        return;
      end
      has_done = (rsp[att] != 2);
      case (rsp[att])
        2:       d = 0;
        3:       d = TO;
        default: d = $urandom_range(1, TO - 1);
      endcase
      fr = fixed ? ffr : mk_frame(rsp[att] != 1);
      ok = has_done && model_csum(fr);
      last = has_done ? s + d : s + TO;
      E = has_done ? s + d + 1 : s + TO;
      if (!has_done) q_abort.push_back(s + TO);
      for (int unsigned c = s + 1; c <= last; c++) begin
        tick_to(c);
        req = (kind == 3 && att == 0 && c == s + 1);
        if (kind == 4 && att == 0 && c == s + 2) en = 1'b0;
        rd_done = has_done && (c == s + d);
        junk = {$urandom, $urandom};
        rd_frame = rd_done ? fr : junk[39:0];
      end
      tick_to(last + 1);
      rd_done = 1'b0;
      req = 1'b0;
      if (kind == 3 && att == 0) served = 1'b1;
      if (ok) begin
        m_data = fr[39:8]; m_valid = 1'b1; m_fail = 1'b0; m_retry = 0; fin = 1'b1;
      end else if (m_retry < MR) begin
        m_retry++;
      end else begin
        m_fail = 1'b1;
        if (m_err != 8'd255) m_err++;
        m_retry = 0;
        fin = 1'b1;
      end
      tick_to(E + 1);
      o = '{E + 1, m_data, m_valid, m_fail, fin && served, m_err};
      q_out.push_back(o);
      gb = E + 1;
      s = gb + G + 1;
      att++;
    end
    en = 1'b0;
    tick_to(gb + 2);
    junk = {$urandom, $urandom};
    rd_frame = junk[39:0];
    rd_done = 1'b1;
    tick_to(gb + 3);
    rd_done = 1'b0;
  endtask

  initial begin : monitor
    bit          pb;
    out_t        o;
    int unsigned e;
    pb = 1'b0;
    forever begin
      @(negedge clk);
      if (!nRST) begin
        pb = 1'b0;
      end else begin
        if (rd_start) begin
          e = (q_start.size() != 0) ? q_start.pop_front() : 0;
          chk("rd_start_cycle", cyc, e);
        end
        if (rd_abort) begin
          e = (q_abort.size() != 0) ? q_abort.pop_front() : 0;
          chk("rd_abort_cycle", cyc, e);
        end
        if (pb && !busy) begin
          if (q_out.size() != 0) o = q_out.pop_front();
          else o = '{0, '0, 1'b0, 1'b0, 1'b0, 8'h00};
          chk("seq_end_cycle", cyc, o.cyc);
          chk("sample", {hum_int, hum_dec, tmp_int, tmp_dec}, o.data);
          chk("valid", valid, o.valid);
          chk("fail", fail, o.fail);
          chk("err_cnt", err_cnt, o.err);
          chk("ack", ack, o.ack);
        end else begin
          chk("ack_idle", ack, 1'b0);
        end
        pb = busy;
      end
    end
  end

  initial begin : watchdog
    #(10 * 90000);
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    tick_to(2);
    check_reset("rst_init");
    tick_to(3);
    nRST = 1'b1;
    gb = 3;
    do_seq(1, 0, 0, 0, 1'b1, 40'h32_00_19_00_4B);
    do_seq(0, 0, 0, 0, 1'b0, '0);
    do_seq(0, 1, 1, 1, 1'b1, 40'h32_00_19_00_4C);
    do_seq(1, 2, 2, 2, 1'b0, '0);
    do_seq(0, 0, 0, 0, 1'b0, '0);
    do_seq(2, 0, 0, 0, 1'b0, '0);
    do_seq(0, 3, 0, 0, 1'b0, '0);
    do_seq(3, 1, 0, 0, 1'b0, '0);
    do_seq(4, 2, 0, 0, 1'b0, '0);
    do_seq(5, 0, 0, 0, 1'b0, '0);
    do_seq(0, 0, 0, 0, 1'b0, '0);
    repeat (14) begin
      do_seq(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0, '0);
    end
    tick_to(cyc + 5);
    chk("start_events_left", q_start.size(), 0);
    chk("abort_events_left", q_abort.size(), 0);
    chk("seq_ends_left", q_out.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
